// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-line bundle for seq_pattern_tx.
// master drives the request side, slave is the transmitter.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_count;
  logic             ready;
  logic             out;
  logic             valid;
  logic             done;

  modport master (
    output start,
    output pattern,
    output repeat_count,
    input  ready,
    input  out,
    input  valid,
    input  done
  );

  modport slave (
    input  start,
    input  pattern,
    input  repeat_count,
    output ready,
    output out,
    output valid,
    output done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out
// MSB-first, back-to-back for a captured repeat count.
module seq_pattern_tx #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input logic             clock,
  input logic             reset,
  seq_pattern_tx_if.slave bus
);

  localparam int BW =
    ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] pat_nx;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nx;
  logic [BW-1:0]    bit_q;
  logic [BW-1:0]    bit_nx;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] rep_nx;

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
    end else begin
      state   <= state_nx;
      pat_q   <= pat_nx;
      shift_q <= shift_nx;
      bit_q   <= bit_nx;
      rep_q   <= rep_nx;
    end
  end

  // next-state: capture, shift, reload between repetitions
  always_comb begin
    state_nx = state;
    pat_nx   = pat_q;
    shift_nx = shift_q;
    bit_nx   = bit_q;
    rep_nx   = rep_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          pat_nx   = bus.pattern;
          shift_nx = bus.pattern;
          rep_nx   = bus.repeat_count;
          if (bus.repeat_count != '0) begin
            state_nx = SHIFT;
            bit_nx   = LAST;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SHIFT: begin
        if (bit_q == '0) begin
          if (rep_q > CNT_W'(1)) begin
            shift_nx = pat_q;
            rep_nx   = rep_q - CNT_W'(1);
            bit_nx   = LAST;
          end else begin
            shift_nx = shift_q << 1;
            state_nx = DONE;
          end
        end else begin
          shift_nx = shift_q << 1;
          bit_nx   = bit_q - BW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state
  always_comb begin
    bus.ready = (state == IDLE);
    bus.valid = (state == SHIFT);
    bus.done  = (state == DONE);
    bus.out   = (state == SHIFT) & shift_q[WIDTH-1];
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a bit-stream
// reference model, at WIDTH=3/CNT_W=4 and WIDTH=8/CNT_W=2.
module tb_seq_pattern_tx;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  bit   ref_bits[$];

  seq_pattern_tx_if #(.WIDTH(3), .CNT_W(4)) a_if ();
  seq_pattern_tx_if #(.WIDTH(8), .CNT_W(2)) b_if ();

  seq_pattern_tx #(.WIDTH(3), .CNT_W(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if.slave)
  );

  seq_pattern_tx #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected serial stream: pattern MSB-first, r times
  function automatic void build_ref(
    input int w, input logic [7:0] p, input int r);
    ref_bits.delete();
    for (int k = 0; k < r; k++)
      for (int i = w - 1; i >= 0; i--)
        ref_bits.push_back(p[i]);
  endfunction

  // expected {ready,valid,done,out} for cycle c after accept
  function automatic logic [3:0] exp_at(input int c);
    int n;
    n = ref_bits.size();
    if (c <= n) return {3'b010, 1'(ref_bits[c-1])};
    if (c == n + 1) return 4'b0010;
    return 4'b1000;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    a_if.start = 1'b0;
    a_if.pattern = '0;
    a_if.repeat_count = '0;
    b_if.start = 1'b0;
    b_if.pattern = '0;
    b_if.repeat_count = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({a_if.ready, a_if.valid, a_if.done, a_if.out}
        !== 4'b1000) begin
      bad++;
      $display("FAIL reset_a got=%b exp=1000",
        {a_if.ready, a_if.valid, a_if.done, a_if.out});
    end
    total++;
    if ({b_if.ready, b_if.valid, b_if.done, b_if.out}
        !== 4'b1000) begin
      bad++;
      $display("FAIL reset_b got=%b exp=1000",
        {b_if.ready, b_if.valid, b_if.done, b_if.out});
    end
    reset = 1'b0;
  endtask

  task automatic test_transfer_a(
    input string name, input logic [2:0] p,
    input int r, input bit scramble);
    logic [3:0] got;
    int n;
    build_ref(3, {5'b0, p}, r);
    n = ref_bits.size();
    @(posedge clock); #1;
    a_if.start = 1'b1;
    a_if.pattern = p;
    a_if.repeat_count = 4'(r);
    @(posedge clock); #1;
    a_if.start = 1'b0;
    if (scramble) begin
      a_if.pattern = 3'($urandom);
      a_if.repeat_count = 4'($urandom);
    end
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clock);
      got = {a_if.ready, a_if.valid, a_if.done, a_if.out};
      total++;
      if (got !== exp_at(c)) begin
        bad++;
        $display("FAIL %s p=%b r=%0d c=%0d got=%b exp=%b",
          name, p, r, c, got, exp_at(c));
      end
      if (scramble && c <= n) a_if.start = 1'($urandom);
      else a_if.start = 1'b0;
    end
  endtask

  task automatic test_basic();
    test_transfer_a("basic", 3'b101, 1, 1'b0);
  endtask

  task automatic test_repeat();
    test_transfer_a("repeat3", 3'b101, 3, 1'b0);
  endtask

  task automatic test_zero_repeat();
    test_transfer_a("zero_rep", 3'b101, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 15; k++)
      test_transfer_a("random", 3'($urandom),
        int'($urandom_range(0, 4)), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    logic [3:0] exp;
    build_ref(3, 8'b110, 2);
    @(posedge clock); #1;
    a_if.start = 1'b1;
    a_if.pattern = 3'b110;
    a_if.repeat_count = 4'd2;
    @(posedge clock);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c <= 8) exp = exp_at(c);
      else exp = exp_at(c - 8);
      got = {a_if.ready, a_if.valid, a_if.done, a_if.out};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL busy c=%0d got=%b exp=%b",
          c, got, exp);
      end
      if (c == 9) a_if.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    logic [3:0] exp;
    build_ref(3, 8'b011, 2);
    @(posedge clock); #1;
    a_if.start = 1'b1;
    a_if.pattern = 3'b011;
    a_if.repeat_count = 4'd2;
    @(posedge clock); #1;
    a_if.start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      got = {a_if.ready, a_if.valid, a_if.done, a_if.out};
      total++;
      if (got !== exp_at(c)) begin
        bad++;
        $display("FAIL rst_mid_pre c=%0d got=%b exp=%b",
          c, got, exp_at(c));
      end
    end
    reset = 1'b1;
    a_if.start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      reset = 1'b0;
      a_if.start = 1'b0;
      exp = 4'b1000;
      got = {a_if.ready, a_if.valid, a_if.done, a_if.out};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rst_mid c=%0d got=%b exp=%b",
          c, got, exp);
      end
    end
  endtask

  task automatic test_width8();
    logic [3:0] got;
    logic [7:0] p;
    int r;
    int n;
    for (int k = 0; k < 5; k++) begin
      p = (k == 0) ? 8'hA5 : 8'($urandom);
      r = (k == 0) ? 3 : int'($urandom_range(0, 3));
      build_ref(8, p, r);
      n = ref_bits.size();
      @(posedge clock); #1;
      b_if.start = 1'b1;
      b_if.pattern = p;
      b_if.repeat_count = 2'(r);
      @(posedge clock); #1;
      b_if.start = 1'b0;
      b_if.pattern = 8'($urandom);
      for (int c = 1; c <= n + 2; c++) begin
        @(negedge clock);
        got = {b_if.ready, b_if.valid, b_if.done, b_if.out};
        total++;
        if (got !== exp_at(c)) begin
          bad++;
          $display("FAIL w8 p=%h r=%0d c=%0d got=%b exp=%b",
            p, r, c, got, exp_at(c));
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_repeat();
    test_zero_repeat();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
